// File: rtl/clk_div.sv
// Dual independent clock divider, 50% duty for even and odd ratios.
// Optional one-cycle rise ticks when CLK_DIV_TICK_EN is defined.
module clk_div_chan #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
`ifdef CLK_DIV_TICK_EN
  output logic tick_o,
`endif
  output logic clk_o
);

  localparam int W = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] HI = W'((DIV + 1) / 2);

  if (DIV < 2) begin : g_bad_div
    $fatal(1, "clk_div: division ratio must be >= 2");
  end

  logic [W-1:0] cnt_q, cnt_d;
  logic         p_q, p_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    p_d   = (cnt_q < HI);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      p_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end

  if (DIV % 2 == 1) begin : g_odd
    // p_q stays high one extra cycle; n_q chops its last half
    logic n_q, n_d;

    always_comb n_d = (cnt_q == HI);

    always_ff @(negedge clk_i or negedge rst_ni) begin
      if (!rst_ni) n_q <= 1'b0;
      else         n_q <= n_d;
    end

    assign clk_o = p_q & ~n_q;
  end else begin : g_even
    assign clk_o = p_q;
  end

`ifdef CLK_DIV_TICK_EN
  logic tick_q, tick_d;

  always_comb tick_d = (cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tick_q <= 1'b0;
    else         tick_q <= tick_d;
  end

  assign tick_o = tick_q;
`endif

endmodule

module clk_div #(
  parameter int DIV1 = 25,
  parameter int DIV2 = 125_000_000
) (
  input  logic clk_in,
  input  logic rst_n,
`ifdef CLK_DIV_TICK_EN
  output logic tick1,
  output logic tick2,
`endif
  output logic clk_out1,
  output logic clk_out2
);

  clk_div_chan #(.DIV(DIV1)) u_ch1 (
    .clk_i  (clk_in),
    .rst_ni (rst_n),
`ifdef CLK_DIV_TICK_EN
    .tick_o (tick1),
`endif
    .clk_o  (clk_out1)
  );

  clk_div_chan #(.DIV(DIV2)) u_ch2 (
    .clk_i  (clk_in),
    .rst_ni (rst_n),
`ifdef CLK_DIV_TICK_EN
    .tick_o (tick2),
`endif
    .clk_o  (clk_out2)
  );

endmodule

// File: tb/tb_clk_div.sv
// Bench for clk_div: three configurations, random reset points,
// half-cycle phase model of every output.
module tb_clk_div;

  logic clk = 1'b0;
  logic rst_n;

  logic a1, a2, b1, b2, c1, c2;
`ifdef CLK_DIV_TICK_EN
  logic at1, at2, bt1, bt2, ct1, ct2;
`endif

  int total = 0;
  int bad = 0;

  always #4 clk = ~clk;

  clk_div u_a (
    .clk_in (clk), .rst_n (rst_n),
`ifdef CLK_DIV_TICK_EN
    .tick1 (at1), .tick2 (at2),
`endif
    .clk_out1 (a1), .clk_out2 (a2)
  );

  clk_div #(.DIV1(3), .DIV2(8)) u_b (
    .clk_in (clk), .rst_n (rst_n),
`ifdef CLK_DIV_TICK_EN
    .tick1 (bt1), .tick2 (bt2),
`endif
    .clk_out1 (b1), .clk_out2 (b2)
  );

  clk_div #(.DIV1(4), .DIV2(5)) u_c (
    .clk_in (clk), .rst_n (rst_n),
`ifdef CLK_DIV_TICK_EN
    .tick1 (ct1), .tick2 (ct2),
`endif
    .clk_out1 (c1), .clk_out2 (c2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // h counts clk edges since the first rising edge after release
  function automatic int m_clk(input int div, input int h, input bit run);
    if (!run) return 0;
    return ((h % (2 * div)) < div) ? 1 : 0;
  endfunction

  function automatic int m_tick(input int div, input int h, input bit run);
    if (!run) return 0;
    return ((h % (2 * div)) < 2) ? 1 : 0;
  endfunction

  bit run = 1'b0;
  int h = 0;

  always @(clk) begin
    if (!rst_n) run = 1'b0;
    else if (clk && !run) begin
      run = 1'b1;
      h = 0;
    end else if (run) h++;
    #2;
    if (rst_n) begin
      chk("a_out1", int'(a1), m_clk(25, h, run));
      chk("a_out2", int'(a2), m_clk(125_000_000, h, run));
      chk("b_out1", int'(b1), m_clk(3, h, run));
      chk("b_out2", int'(b2), m_clk(8, h, run));
      chk("c_out1", int'(c1), m_clk(4, h, run));
      chk("c_out2", int'(c2), m_clk(5, h, run));
`ifdef CLK_DIV_TICK_EN
      chk("a_tick1", int'(at1), m_tick(25, h, run));
      chk("b_tick2", int'(bt2), m_tick(8, h, run));
      chk("c_tick1", int'(ct1), m_tick(4, h, run));
      chk("c_tick2", int'(ct2), m_tick(5, h, run));
`endif
    end
  end

  bit cnt_en = 1'b0;
  int n_a1 = 0;
  int n_b1 = 0;
  int n_b2 = 0;

  always @(posedge a1) if (cnt_en) n_a1++;
  always @(posedge b1) if (cnt_en) n_b1++;
  always @(posedge b2) if (cnt_en) n_b2++;

  task automatic chk_zero();
    chk("rst_a1", int'(a1), 0);
    chk("rst_a2", int'(a2), 0);
    chk("rst_b1", int'(b1), 0);
    chk("rst_b2", int'(b2), 0);
    chk("rst_c1", int'(c1), 0);
    chk("rst_c2", int'(c2), 0);
  endtask

  initial begin
    int wait_cyc;
    rst_n = 1'b0;
    #1 chk_zero();
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_cyc = (i == 0) ? 110 : int'($urandom_range(40, 400));
      repeat (wait_cyc) @(posedge clk);
      #1;
      if (i == 0) chk("pre_rst_a1_high", int'(a1), 1);
      rst_n = 1'b0;
      #1 chk_zero();
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1 chk_zero();
      @(negedge clk);
      #1 rst_n = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1;
    cnt_en = 1'b1;
    rst_n = 1'b1;
    repeat (10000) @(posedge clk);
    #1 cnt_en = 1'b0;
    chk("a1_rises_10k", n_a1, 400);
    chk("b1_rises_10k", n_b1, 3334);
    chk("b2_rises_10k", n_b2, 1250);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div.md
CLK_DIV -- requirements
Module: clk_div

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk_in (clock) and rst_n (reset).
REQ-002 Parameter DIV1, default 25, SHALL set the clk_in-to-clk_out1 division ratio (125 MHz -> 5 MHz).
REQ-003 Parameter DIV2, default 125_000_000, SHALL set the clk_in-to-clk_out2 division ratio (125 MHz -> 1 Hz).
REQ-004 Port clk_in, input, 1 bit: source clock, nominally 125 MHz.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port clk_out1, output, 1 bit: clk_in divided by DIV1, 50% duty.
REQ-007 Port clk_out2, output, 1 bit: clk_in divided by DIV2, 50% duty.

Function
REQ-008 Each output SHALL be produced by an independent divider channel: a counter 0..DIVn-1 on clk_in rising edges, wrapping to 0 after DIVn-1.
REQ-009 Counter widths SHALL be $clog2(DIVn) bits; no overflow SHALL occur for any legal DIVn.
REQ-010 Each output period SHALL be exactly DIVn clk_in periods, with no jitter and no drift.
REQ-011 For even DIVn: the output SHALL be high for DIVn/2 clk_in periods and low for DIVn/2 periods; both edges SHALL be aligned to clk_in rising edges.
REQ-012 For odd DIVn: the output SHALL be high for (DIVn-1)/2 + 0.5 periods and low for the same; the rise SHALL align to a clk_in rising edge and the fall to a clk_in falling edge.
REQ-013 The odd-ratio half-period SHALL be realised by combining a rising-edge phase register with a falling-edge-retimed copy; outputs SHALL come from registers or a glitch-free AND of registers.
REQ-014 After reset release, the first rising edge of each output SHALL occur at the first clk_in rising edge; thereafter outputs SHALL rise every DIVn periods.
REQ-015 Parameters SHALL be checked at elaboration: DIVn < 2 is a fatal error.
REQ-016 The clk_out1 and clk_out2 channels SHALL NOT interact; a change in one SHALL never affect the timing of the other.

Reset
REQ-017 rst_n low SHALL immediately, without a clock, force clk_out1 = 0, clk_out2 = 0, and all counters and phase registers to 0.
REQ-018 Reset asserted mid-period SHALL truncate the current output pulse; no glitch SHALL occur other than the forced transition to 0.
REQ-019 Reset deassertion SHALL be treated as synchronous to clk_in; outputs SHALL stay 0 until the first clk_in rising edge after release.

Configuration
REQ-020 When the macro CLK_DIV_TICK_EN is defined, outputs tick1 and tick2 (1 bit each) SHALL exist.
REQ-021 With CLK_DIV_TICK_EN, tickn SHALL be high for exactly one clk_in period, starting at the clk_in rising edge where clk_outn rises, and SHALL reset to 0.
REQ-022 Without CLK_DIV_TICK_EN, tick1 and tick2 SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-023 Defaults, reset for 5 clk_in cycles then release -> clk_out1 rises at the first clk_in edge; period 200 ns; high 100 ns, low 100 ns; first 3 periods checked.
REQ-024 Override DIV2=8, reset then release -> clk_out2 high 4 clk_in cycles, low 4 cycles, repeating; 4 periods checked.
REQ-025 Override DIV1=3 -> clk_out1 high 1.5 clk_in periods and low 1.5 periods, rising on a clk_in rising edge and falling on a clk_in falling edge; no glitches.
REQ-026 rst_n pulled low mid-high-phase of clk_out1 (defaults) -> clk_out1 and clk_out2 are 0 within the same timestep; after release, the first rise is at the first clk_in edge.
REQ-027 CLK_DIV_TICK_EN defined, DIV1=4 -> tick1 is a one-cycle pulse every 4 clk_in cycles, coincident with each clk_out1 rise.
REQ-028 Defaults over 10,000 clk_in cycles -> exactly 400 clk_out1 rising edges; clk_out2 stays high, with no falling edge (half-period 62,500,000 cycles).
